// File: rtl/reg_file_sb_if.sv
// Bus between the decode/writeback stages and the scoreboarded register file.
// The master drives addresses, write data and reservations; the slave returns registered read data and status.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rbusy1;
  logic              rbusy2;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              resv_en;
  logic [ADDR_W-1:0] resv_addr;
  logic              werr;

  modport master (
    output raddr1, raddr2, waddr, wdata, wen, resv_en, resv_addr,
    input  rdata1, rdata2, rbusy1, rbusy2, werr
  );

  modport slave (
    input  raddr1, raddr2, waddr, wdata, wen, resv_en, resv_addr,
    output rdata1, rdata2, rbusy1, rbusy2, werr
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with one write port, two registered read ports, optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard for RAW hazard detection.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr_ok;
  logic              resv_ok;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;
  logic              rb1_next;
  logic              rb2_next;

  assign wr_ok   = bus.wen && !(ZERO_REG && bus.waddr == '0);
  assign resv_ok = bus.resv_en && !(ZERO_REG && bus.resv_addr == '0);

  // Reserve is applied after release so a producer issuing as the old one retires keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (wr_ok) busy_next[bus.waddr] = 1'b0;
    if (resv_ok) busy_next[bus.resv_addr] = 1'b1;
  end

  always_comb begin
    rd1_next = regs[bus.raddr1];
    rb1_next = BYPASS ? busy_next[bus.raddr1] : busy[bus.raddr1];
    if (BYPASS && wr_ok && bus.waddr == bus.raddr1) rd1_next = bus.wdata;
    if (ZERO_REG && bus.raddr1 == '0) begin
      rd1_next = '0;
      rb1_next = 1'b0;
    end
  end

  always_comb begin
    rd2_next = regs[bus.raddr2];
    rb2_next = BYPASS ? busy_next[bus.raddr2] : busy[bus.raddr2];
    if (BYPASS && wr_ok && bus.waddr == bus.raddr2) rd2_next = bus.wdata;
    if (ZERO_REG && bus.raddr2 == '0) begin
      rd2_next = '0;
      rb2_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy       <= '0;
      bus.rdata1 <= '0;
      bus.rdata2 <= '0;
      bus.rbusy1 <= 1'b0;
      bus.rbusy2 <= 1'b0;
      bus.werr   <= 1'b0;
    end else begin
      if (wr_ok) regs[bus.waddr] <= bus.wdata;
      busy       <= busy_next;
      bus.rdata1 <= rd1_next;
      bus.rdata2 <= rd2_next;
      bus.rbusy1 <= rb1_next;
      bus.rbusy2 <= rb2_next;
      bus.werr   <= wr_ok && !busy[bus.waddr];
    end
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file for the lab CPU datapath: one write port, two registered read ports, and a hardwired zero register.
- Adds an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can detect RAW hazards on registers with an outstanding write.
- Sits between decode (read and reserve) and writeback (write and release).

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 4, register address width; depth = 2**ADDR_W
BYPASS, 1, 1 = reads return a same-edge write and scoreboard update; 0 = reads return pre-edge state
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
Clock  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-high reset
RAddr1  in  ADDR_W  read port 1 address
RAddr2  in  ADDR_W  read port 2 address
RData1  out  DATA_W  registered read data, port 1
RData2  out  DATA_W  registered read data, port 2
RBusy1  out  1  registered busy flag of RAddr1
RBusy2  out  1  registered busy flag of RAddr2
WAddr  in  ADDR_W  write address
WData  in  DATA_W  write data
Wen  in  1  write enable; also releases busy[WAddr]
ResvEn  in  1  reserve enable; sets busy[ResvAddr]
ResvAddr  in  ADDR_W  register being reserved by an issuing instruction
WErr  out  1  registered 1-cycle pulse: write to a register that was not busy

Behaviour:
- Clock is the single clock. Reset is asynchronous and active-high.
- Reset (asynchronous, active-high):
  - all registers clear to 0; all busy bits clear to 0;
  - RData1/2 = 0, RBusy1/2 = 0, WErr = 0;
  - takes effect immediately and holds while asserted;
  - the first update happens on the first rising edge after deassertion;
  - an in-flight write or reserve on the asserting edge is discarded.
- Write: on the rising edge with Wen=1, regs[WAddr] <= WData.
  - If ZERO_REG=1 and WAddr=0, the write is dropped.
  - Otherwise the full DATA_W is written; there is no partial write.
- Read: RDataN and RBusyN update every rising edge, giving 1-cycle latency from address to data. There is no read enable.
  - BYPASS=1: if Wen=1 and WAddr=RAddrN (and not the zero register), RDataN <= WData. Otherwise RDataN <= regs[RAddrN].
  - BYPASS=0: RDataN <= regs[RAddrN] as it was before the edge.
  - ZERO_REG=1 and RAddrN=0: RDataN <= 0 and RBusyN <= 0, regardless of bypass.
  - Both ports may address the same register; each port is evaluated independently.
- Scoreboard, per edge:
  - Wen=1 clears busy[WAddr].
  - ResvEn=1 sets busy[ResvAddr].
  - Same edge, ResvAddr=WAddr: reserve wins and the bit ends set (a new producer issues as the old one retires).
  - ResvAddr=0 with ZERO_REG=1: ignored.
- RBusyN:
  - BYPASS=1: the post-edge busy value of RAddrN.
  - BYPASS=0: the pre-edge value.
- WErr <= 1 on the edge after any Wen=1 to an address whose pre-edge busy bit was 0, excluding the zero register when ZERO_REG=1. Otherwise WErr <= 0. The write itself is still performed.
- Addresses are always in range (depth = 2**ADDR_W); no wrap or clamp logic is needed.
- There is no write-port conflict: single write port.

Test Plan:
1. Reset, then read all 16 addresses on both ports -> RData1/2=0x0000 and RBusy1/2=0 for every address; WErr never asserts.
2. Wen=1, WAddr=5, WData=0xBEEF; next cycle RAddr1=5 -> RData1=0xBEEF one edge later. Wen=1, WAddr=0, WData=0x1234 -> RAddr2=0 reads 0x0000.
3. BYPASS=1, same edge Wen=1, WAddr=3, WData=0xA5A5 and RAddr1=RAddr2=3 -> both ports show 0xA5A5 after that edge. BYPASS=0 build, same stimulus -> both ports show the old value 0x0000, then 0xA5A5 one edge later.
4. ResvEn=1, ResvAddr=7 -> RBusy1 (RAddr1=7) =1. Later Wen=1, WAddr=7, WData=0x0042 -> busy clears, WErr stays 0. A second write to 7 -> WErr=1 for exactly one cycle and regs[7]=new data.
5. Same edge ResvEn=1, ResvAddr=9 and Wen=1, WAddr=9, with reg 9 previously busy -> reg 9 updated, busy[9] remains 1, WErr=0. ResvAddr=0 -> RBusy on address 0 stays 0.
6. Write 0xFFFF to reg 2 and reserve reg 4, then assert Reset mid-cycle, asynchronously between edges -> RData1/2, RBusy1/2 and WErr drop to 0 immediately. After release, reg 2 reads 0x0000 and reg 4 is not busy.
